// File: rtl/coef_multiplier.sv
// coef_multiplier: per-tap coefficient multiply with 2-cycle latency (COEF_MULT_DOUBLE_BUF_EN adds shadow/active coefficient banks)
module coef_multiplier #(
  parameter int DATA_WIDTH     = 18,
  parameter int COEF_WIDTH     = 18,
  parameter int DATA_LENGTH    = 9,
  parameter int COUNTER_LENGTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          inputValue,
  input  logic                           de,
  input  logic                           restart,
  input  logic                           coefWe,
  input  logic [COUNTER_LENGTH-1:0]      coefAddr,
  input  logic [COEF_WIDTH-1:0]          coefData,
  input  logic                           coefCommit,
  output logic [DATA_WIDTH+COEF_WIDTH-1:0] valueOut,
  output logic                           deOut,
  output logic [COUNTER_LENGTH-1:0]      indexOut
);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam logic [COUNTER_LENGTH-1:0] LAST = COUNTER_LENGTH'(DATA_LENGTH - 1);
  logic [COUNTER_LENGTH-1:0] idx_q, idx_d, use_idx;
  logic [COEF_WIDTH-1:0]     rd_coef;
  logic                      wr_ok;
  logic [DATA_WIDTH-1:0]     s1_val_q;
  logic [COEF_WIDTH-1:0]     s1_coef_q;
  logic                      s1_de_q, s2_de_q;
  logic [COUNTER_LENGTH-1:0] s1_idx_q, s2_idx_q;
  logic [PW-1:0]             prod_q;
  // restart realigns the window so the current sample lands on tap 0
  assign use_idx = restart ? '0 : idx_q;
  assign wr_ok = coefWe && ({1'b0, coefAddr} < (COUNTER_LENGTH+1)'(DATA_LENGTH));
  // tap index advances only on accepted samples and wraps at the last tap
  always_comb idx_d = de ? ((use_idx == LAST) ? '0 : use_idx + COUNTER_LENGTH'(1)) : use_idx;
`ifdef COEF_MULT_DOUBLE_BUF_EN
  logic [COEF_WIDTH-1:0] active_q [DATA_LENGTH];
  logic [COEF_WIDTH-1:0] shadow_q [DATA_LENGTH];
  logic                  pending_q, swap;
  // swap only right before tap 0 so a window never mixes banks
  assign swap = pending_q && (use_idx == '0);
  assign rd_coef = swap ? shadow_q[use_idx] : active_q[use_idx];
  // writes land in the shadow bank; a swap publishes it to the active bank
  always_ff @(posedge clk) begin
    if (wr_ok) shadow_q[coefAddr] <= coefData;
    if (swap) active_q <= shadow_q;
  end
  // a commit request stays pending until the next window boundary
  always_ff @(posedge clk) begin
    if (reset) pending_q <= 1'b0;
    else pending_q <= !swap && (pending_q || coefCommit);
  end
`else
  logic [COEF_WIDTH-1:0] coef_q [DATA_LENGTH];
  logic                  unused_commit;
  assign unused_commit = coefCommit;
  assign rd_coef = coef_q[use_idx];
  // coefficient storage is never reset; a same-cycle read sees the old value
  always_ff @(posedge clk) begin
    if (wr_ok) coef_q[coefAddr] <= coefData;
  end
`endif
  // tap index plus the two pipeline stages, all cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q     <= '0;
      s1_val_q  <= '0;
      s1_coef_q <= '0;
      s1_de_q   <= 1'b0;
      s1_idx_q  <= '0;
      prod_q    <= '0;
      s2_de_q   <= 1'b0;
      s2_idx_q  <= '0;
    end else begin
      idx_q     <= idx_d;
      s1_val_q  <= inputValue;
      s1_coef_q <= rd_coef;
      s1_de_q   <= de;
      s1_idx_q  <= use_idx;
      prod_q    <= PW'(s1_val_q) * PW'(s1_coef_q);
      s2_de_q   <= s1_de_q;
      s2_idx_q  <= s1_idx_q;
    end
  end
  assign valueOut = s2_de_q ? prod_q : '0;
  assign deOut    = s2_de_q;
  assign indexOut = s2_idx_q;
endmodule

// File: tb/tb_coef_multiplier.sv
// tb_coef_multiplier: directed stimulus with a reference model feeding an output scoreboard
module tb_coef_multiplier;
  localparam int DW = 18, CW = 18, DL = 9, CL = 4, PW = 36;
  logic clk = 1'b0;
  logic reset, de, restart, coefWe, coefCommit;
  logic [DW-1:0] inputValue;
  logic [CL-1:0] coefAddr;
  logic [CW-1:0] coefData;
  logic [PW-1:0] valueOut;
  logic deOut;
  logic [CL-1:0] indexOut;
  typedef struct {logic [PW-1:0] v; logic [CL-1:0] i; int s;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, edge_n = 0;
  logic mon_en = 1'b0;
  logic [CW-1:0] mact [DL];
  logic [CW-1:0] mshad [DL];
  logic [CL-1:0] midx;
  logic mpend;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  coef_multiplier #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .DATA_LENGTH(DL), .COUNTER_LENGTH(CL)) dut (
    .clk(clk), .reset(reset), .inputValue(inputValue), .de(de), .restart(restart),
    .coefWe(coefWe), .coefAddr(coefAddr), .coefData(coefData), .coefCommit(coefCommit),
    .valueOut(valueOut), .deOut(deOut), .indexOut(indexOut));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step(input logic d, input logic [DW-1:0] v, input logic rs = 1'b0, input logic we = 1'b0,
                      input logic [CL-1:0] a = '0, input logic [CW-1:0] wd = '0, input logic cm = 1'b0);
    logic [CL-1:0] u;
    logic sw;
    logic [CW-1:0] c;
    exp_t e;
    de = d; inputValue = v; restart = rs; coefWe = we; coefAddr = a; coefData = wd; coefCommit = cm;
    u = rs ? '0 : midx;
`ifdef COEF_MULT_DOUBLE_BUF_EN
    sw = mpend && (u == '0);
    c = sw ? mshad[u] : mact[u];
    if (sw) mact = mshad;
    if (we && a < DL) mshad[a] = wd;
    mpend = !sw && (mpend || cm);
`else
    sw = 1'b0;
    c = mact[u];
    if (we && a < DL) mact[a] = wd;
`endif
    e.v = PW'(v) * PW'(c);
    e.i = u;
    e.s = 0;
    if (d) midx = (u == CL'(DL - 1)) ? '0 : u + 1'b1;
    else midx = u;
    @(posedge clk); #1;
    if (d) begin
      e.s = edge_n;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; de = 1'b0; restart = 1'b0; coefWe = 1'b0; coefCommit = 1'b0;
    while (sb.size() > 0 && sb[$].s >= edge_n) void'(sb.pop_back());
    midx = '0;
    mpend = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic commit_idle();
`ifdef COEF_MULT_DOUBLE_BUF_EN
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, '0);
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (deOut) begin
        if (sb.size() == 0) chk("unexpected_deOut", 64'(deOut), 64'd0);
        else begin
          e = sb.pop_front();
          chk("valueOut", 64'(valueOut), 64'(e.v));
          chk("indexOut", 64'(indexOut), 64'(e.i));
          chk("latency", 64'(edge_n), 64'(e.s + 1));
        end
      end else chk("gated_zero", 64'(valueOut), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < DL; k++) begin mact[k] = '0; mshad[k] = '0; end
    inputValue = '0; coefAddr = '0; coefData = '0;
    do_reset(3);
    chk("reset_deOut", 64'(deOut), 64'd0);
    chk("reset_valueOut", 64'(valueOut), 64'd0);
    chk("reset_indexOut", 64'(indexOut), 64'd0);
    mon_en = 1'b1;
    for (int k = 0; k < DL; k++) step(1'b0, '0, 1'b0, 1'b1, CL'(k), CW'(k + 1));
    commit_idle();
    for (int k = 0; k < 10; k++) step(1'b1, DW'(100));
    repeat (3) step(1'b0, '0);
    step(1'b0, '0, 1'b1);
    step(1'b1, DW'(5));
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b1, DW'(7));
    repeat (3) step(1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, CL'(2), '1);
    commit_idle();
    step(1'b1, '1);
    step(1'b0, '0, 1'b0, 1'b1, CL'(2), CW'(3));
    commit_idle();
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b1, DW'(k + 1));
    step(1'b1, DW'(11), 1'b1);
    step(1'b1, DW'(13));
    step(1'b1, DW'(10), 1'b0, 1'b1, CL'(2), CW'(50));
    for (int k = 0; k < DL; k++) step(1'b1, DW'(10));
    step(1'b0, '0, 1'b0, 1'b1, CL'(12), CW'(999));
    for (int k = 0; k < DL; k++) step(1'b1, DW'(1));
    step(1'b1, DW'(20));
    step(1'b1, DW'(21));
    do_reset(1);
    step(1'b1, DW'(30));
    repeat (3) step(1'b0, '0);
`ifdef COEF_MULT_DOUBLE_BUF_EN
    for (int k = 0; k < DL; k++) step(1'b0, '0, 1'b0, 1'b1, CL'(k), CW'(2));
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, DW'(10));
    step(1'b1, DW'(10), 1'b0, 1'b0, '0, '0, 1'b1);
    for (int k = 0; k < 13; k++) step(1'b1, DW'(10));
`endif
    repeat (4) step(1'b0, '0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
